// File: rtl/fsk_rx_frame_ctrl.sv
// rtl/fsk_rx_frame_ctrl.sv - FSK tone-window sequencer, bit voter and async character framer
module fsk_rx_frame_ctrl #(
   parameter int WIN_LEN     = 16,
   parameter int CNT_W       = 10,
   parameter int MARK_TH     = 5,
   parameter int WIN_PER_BIT = 4,
   parameter int DATA_BITS   = 8
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic [CNT_W-1:0] edge_cnt,
   output logic             cnt_clr_n,
   output logic             cnt_en,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam int WB_W  = $clog2(WIN_PER_BIT + 1);

   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
   localparam logic [WB_W-1:0]  WB_LAST  = WB_W'(WIN_PER_BIT - 1);
   localparam logic [WB_W:0]    WB_NUM   = (WB_W + 1)'(WIN_PER_BIT);
   localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] TH       = CNT_W'(MARK_TH);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] STOP      = 3'd3;
   localparam logic [2:0] WAIT_MARK = 3'd4;

   logic [WIN_W-1:0] r_win_cnt;
   logic             r_clr_n;
   logic             r_cnt_en;
   logic             r_tone;
   logic             r_tone_stb;
   logic [2:0]       r_state;
   logic [WB_W-1:0]  r_win_idx;
   logic [WB_W-1:0]  r_marks;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic [7:0]       r_rx_data;
   logic             r_rx_valid;
   logic             r_frame_err;
   logic             r_overrun;

   logic            w_boundary;
   logic [WB_W-1:0] w_m_next;
   logic            w_vote;
   logic            w_bit_done;

   assign w_boundary = (r_win_cnt == WIN_LAST);
   assign w_m_next   = r_marks + WB_W'(r_tone);
   // Ties between mark and space windows resolve to mark.
   assign w_vote     = ({w_m_next, 1'b0} >= WB_NUM);
   assign w_bit_done = (r_win_idx == WB_LAST);

   always_ff @(posedge sysclk) begin
      if (!reset) begin
         r_win_cnt   <= '0;
         r_clr_n     <= 1'b0;
         r_cnt_en    <= 1'b0;
         r_tone      <= 1'b1;
         r_tone_stb  <= 1'b0;
         r_state     <= IDLE;
         r_win_idx   <= '0;
         r_marks     <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_cnt_en    <= 1'b1;
         r_clr_n     <= ~w_boundary;
         r_win_cnt   <= w_boundary ? '0 : r_win_cnt + 1'b1;
         r_tone_stb  <= w_boundary;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         // No carrier at all (zero edges) reads as the idle mark tone.
         if (w_boundary)
            r_tone <= (edge_cnt > TH) || (edge_cnt == '0);
         if (r_rx_valid && rx_ready)
            r_rx_valid <= 1'b0;

         if (r_tone_stb) begin
            if (r_state == START || r_state == DATA || r_state == STOP) begin
               r_win_idx <= w_bit_done ? '0 : r_win_idx + 1'b1;
               r_marks   <= w_bit_done ? '0 : w_m_next;
            end
            case (r_state)
               IDLE: begin
                  if (!r_tone) begin
                     r_win_idx <= (WIN_PER_BIT == 1) ? '0 : WB_W'(1);
                     r_marks   <= '0;
                     r_bit_idx <= '0;
                     r_shift   <= '0;
                     r_state   <= (WIN_PER_BIT == 1) ? DATA : START;
                  end
               end
               START: begin
                  if (w_bit_done)
                     r_state <= w_vote ? IDLE : DATA;
               end
               DATA: begin
                  if (w_bit_done) begin
                     r_shift[r_bit_idx] <= w_vote;
                     r_bit_idx          <= r_bit_idx + 1'b1;
                     if (r_bit_idx == BIT_LAST)
                        r_state <= STOP;
                  end
               end
               STOP: begin
                  if (w_bit_done) begin
                     if (w_vote) begin
                        if (!r_rx_valid || rx_ready) begin
                           r_rx_data  <= r_shift;
                           r_rx_valid <= 1'b1;
                        end else begin
                           r_overrun <= 1'b1;
                        end
                        r_state <= IDLE;
                     end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= WAIT_MARK;
                     end
                  end
               end
               WAIT_MARK: begin
                  if (r_tone)
                     r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign cnt_clr_n = r_clr_n;
   assign cnt_en    = r_cnt_en;
   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fsk_rx_frame_ctrl.sv
// tb/tb_fsk_rx_frame_ctrl.sv - directed bench for fsk_rx_frame_ctrl at default parameters
module tb_fsk_rx_frame_ctrl;

   logic       sysclk = 1'b0;
   logic       reset = 1'b0;
   logic [9:0] edge_cnt = 10'd8;
   logic       rx_ready = 1'b0;
   logic       cnt_clr_n, cnt_en, rx_valid, frame_err, overrun, busy;
   logic [7:0] rx_data;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 sysclk = ~sysclk;

   fsk_rx_frame_ctrl dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .edge_cnt  (edge_cnt),
      .cnt_clr_n (cnt_clr_n),
      .cnt_en    (cnt_en),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
      cyc++;
   endtask

   // Holds edge_cnt until the next window boundary; returns in the tone-strobe cycle.
   task automatic send_window(input int v);
      edge_cnt = 10'(v);
      do tick(); while (cyc % 16 != 0);
   endtask

   task automatic send_win4(input int a, input int b, input int c, input int d);
      send_window(a);
      send_window(b);
      send_window(c);
      send_window(d);
   endtask

   task automatic send_char(input logic [7:0] ch, input bit stop_mark);
      send_win4(3, 3, 3, 3);
      for (int i = 0; i < 8; i++) begin
         if (ch[i]) send_win4(8, 8, 8, 8);
         else       send_win4(3, 3, 3, 3);
      end
      if (stop_mark) send_win4(8, 8, 8, 8);
      else           send_win4(3, 3, 3, 3);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) tick();
      chk("rst_clr_n", cnt_clr_n, 0);
      chk("rst_en", cnt_en, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_valid", rx_valid, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b1;
      cyc   = 0;
   endtask

   task automatic check_window_timing();
      edge_cnt = 10'd8;
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (k == 1) chk("cnt_en", cnt_en, 1);
         chk("clr_n", cnt_clr_n, (k % 16 == 0) ? 16'd0 : 16'd1);
      end
   endtask

   task automatic consume();
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      chk("consume_valid", rx_valid, 0);
   endtask

   initial begin
      do_reset();
      check_window_timing();

      // 0xA5 with latency and hold checks
      send_char(8'hA5, 1'b1);
      chk("a5_early", rx_valid, 0);
      tick();
      chk("a5_valid", rx_valid, 1);
      chk("a5_data", rx_data, 16'h00A5);
      chk("a5_busy", busy, 0);
      repeat (3) tick();
      chk("a5_hold_valid", rx_valid, 1);
      chk("a5_hold_data", rx_data, 16'h00A5);
      consume();

      // thresholds and vote: expected 0xAE
      send_win4(3, 3, 3, 3);
      send_win4(5, 5, 5, 5);
      send_win4(6, 6, 6, 6);
      send_win4(0, 0, 0, 0);
      send_win4(8, 3, 8, 3);
      send_win4(8, 3, 3, 3);
      send_win4(3, 8, 8, 8);
      send_win4(1, 1, 1, 1);
      send_win4(8, 8, 8, 3);
      send_win4(8, 8, 8, 8);
      tick();
      chk("vote_valid", rx_valid, 1);
      chk("vote_data", rx_data, 16'h00AE);
      consume();

      // glitch start
      send_window(3);
      tick();
      chk("glitch_busy_hi", busy, 1);
      send_window(8);
      send_window(8);
      send_window(8);
      tick();
      chk("glitch_busy_lo", busy, 0);
      chk("glitch_valid", rx_valid, 0);
      chk("glitch_ferr", frame_err, 0);

      // framing error, then start-like spaces ignored until a mark
      send_window(8);
      send_char(8'h3C, 1'b0);
      tick();
      chk("ferr_pulse", frame_err, 1);
      chk("ferr_valid", rx_valid, 0);
      tick();
      chk("ferr_end", frame_err, 0);
      send_win4(3, 3, 3, 3);
      tick();
      chk("wait_busy", busy, 1);
      chk("wait_valid", rx_valid, 0);
      send_window(8);
      send_char(8'h5A, 1'b1);
      tick();
      chk("recover_valid", rx_valid, 1);
      chk("recover_data", rx_data, 16'h005A);
      consume();

      // overrun with rx_ready held low
      send_char(8'h11, 1'b1);
      send_char(8'h22, 1'b1);
      tick();
      chk("ovr_pulse", overrun, 1);
      chk("ovr_data", rx_data, 16'h0011);
      chk("ovr_valid", rx_valid, 1);
      tick();
      chk("ovr_end", overrun, 0);
      consume();

      // simultaneous consume and load
      send_char(8'h11, 1'b1);
      send_char(8'h22, 1'b1);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      chk("swap_ovr", overrun, 0);
      chk("swap_valid", rx_valid, 1);
      chk("swap_data", rx_data, 16'h0022);

      // reset mid-frame with a pending character
      send_window(3);
      send_window(3);
      tick();
      chk("mid_busy", busy, 1);
      do_reset();
      check_window_timing();
      send_char(8'h96, 1'b1);
      tick();
      chk("post_rst_valid", rx_valid, 1);
      chk("post_rst_data", rx_data, 16'h0096);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
